sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker.sv | 143 ++++++++++++++
 tb/tb_sysid_checker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Reads the system-ID slave (word 0 = ID, word 1 = build timestamp) over Avalon-MM
// and compares both words against the expected build values, with per-read timeout and retry.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1579770612,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, FIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        auto_q, auto_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;

  logic rd, ack, tmo_hit;

  // The wait count equals TIMEOUT_CYCLES on the cycle after the last allowed stall;
  // that cycle either completes (waitrequest low) or becomes the one-cycle read gap.
  // avm_read therefore depends combinationally on avm_waitrequest in that cycle only.
  assign rd      = (state_q == RD_ID) || (state_q == RD_TS);
  assign ack     = rd && !avm_waitrequest;
  assign tmo_hit = rd && avm_waitrequest && (wcnt_q == 16'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    retry_d  = retry_q;
    auto_d   = auto_q;
    pass_d   = pass_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    tmo_d    = tmo_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d = RD_ID;
          auto_d  = 1'b0;
          pass_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
          retry_d = '0;
          wcnt_d  = '0;
        end
      end
      RD_ID, RD_TS: begin
        if (ack) begin
          wcnt_d = '0;
          if (state_q == RD_ID) begin
            id_val_d = avm_readdata;
            state_d  = RD_TS;
          end else begin
            ts_val_d = avm_readdata;
            state_d  = CHECK;
          end
        end else if (tmo_hit) begin
          wcnt_d = '0;
          if (retry_q < 4'(MAX_RETRIES)) begin
            retry_d = retry_q + 4'd1;
          end else begin
            tmo_d   = 1'b1;
            state_d = FIN;
          end
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      CHECK: begin
        id_ok_d = (id_val_q == EXPECTED_ID);
        ts_ok_d = (ts_val_q == EXPECTED_TS);
        pass_d  = (id_val_q == EXPECTED_ID) && (ts_val_q == EXPECTED_TS);
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      retry_q  <= '0;
      auto_q   <= AUTO_START;
      pass_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      tmo_q    <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      retry_q  <= retry_d;
      auto_q   <= auto_d;
      pass_q   <= pass_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      tmo_q    <= tmo_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  assign avm_read    = rd && !tmo_hit;
  assign avm_address = (state_q == RD_TS);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: stalling slave model, vector table, plus
// reset/auto-start, timeout waveform, mid-read reset and start-while-busy sequences.
module tb_sysid_checker;

  localparam logic [31:0] TS = 32'd1579770612;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  logic [31:0] id_word, ts_word;
  int          stall_id, stall_ts, scnt;
  int          checks = 0, failures = 0;

  always #5 clock = ~clock;

  sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
  );

  // Slave stalls each read for stall_* strobed cycles, then answers.
  assign avm_waitrequest = ((avm_address ? stall_ts : stall_id) > scnt);
  assign avm_readdata    = avm_address ? ts_word : id_word;

  always @(posedge clock) begin
    if (!busy)                            scnt <= 0;
    else if (avm_read && avm_waitrequest) scnt <= scnt + 1;
    else if (avm_read)                    scnt <= 0;
  end

  typedef struct {
    logic [31:0] id_w, ts_w;
    int          s_id, s_ts;
    logic [3:0]  e_flags;  // {pass, id_ok, ts_ok, timeout_err}
    int          e_lat;
    logic [31:0] e_idv, e_tsv;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int lat, ndone;
  logic [9:0] rdbits;
  logic       addr_any;

  initial begin
    vecs[0] = '{32'h0,         TS,            0,    0,    4'b1110, 3,  32'h0,         TS};
    vecs[1] = '{32'h0,         32'h1234_5678, 0,    0,    4'b0100, 3,  32'h0,         32'h1234_5678};
    vecs[2] = '{32'h1,         TS,            0,    0,    4'b0010, 3,  32'h1,         TS};
    vecs[3] = '{32'h8000_0000, TS ^ 32'h1,    0,    0,    4'b0000, 3,  32'h8000_0000, TS ^ 32'h1};
    vecs[4] = '{32'h0,         TS,            0,    4,    4'b1110, 7,  32'h0,         TS};
    vecs[5] = '{32'h0,         TS,            5,    0,    4'b1110, 9,  32'h0,         TS};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0,         1000, 0,    4'b0001, 10, 32'h0,         TS};
    vecs[7] = '{32'hA5A5_0001, 32'hDEAD_BEEF, 0,    1000, 4'b0001, 11, 32'hA5A5_0001, TS};
    vecs[8] = '{32'h0,         32'h0BAD_0BAD, 5,    5,    4'b0001, 12, 32'h0,         TS};
    vecs[9] = '{32'h0,         TS,            3,    2,    4'b1110, 8,  32'h0,         TS};

    reset = 1'b1; start = 1'b0;
    id_word = 32'h0; ts_word = TS; stall_id = 0; stall_ts = 0;
    repeat (3) tick();
    chk("reset_ctrl", {28'h0, avm_read, avm_address, busy, done}, 32'h0);
    chk("reset_stat", {28'h0, pass, id_ok, ts_ok, timeout_err}, 32'h0);
    chk("reset_vals", id_value | ts_value, 32'h0);

    // Auto-start: edge 1 after release launches the check, done in cycle 4.
    reset = 1'b0;
    tick();
    chk("auto_c1_rd_addr0", {30'h0, avm_read, avm_address}, 32'h2);
    tick();
    chk("auto_c2_rd_addr1", {30'h0, avm_read, avm_address}, 32'h3);
    tick();
    chk("auto_c3_no_done", {30'h0, avm_read, done}, 32'h0);
    tick();
    chk("auto_c4_done", {28'h0, done, pass, id_ok, ts_ok}, 32'hF);
    tick();
    chk("auto_done_1cyc", {30'h0, done, busy}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      id_word = vecs[i].id_w; ts_word = vecs[i].ts_w;
      stall_id = vecs[i].s_id; stall_ts = vecs[i].s_ts;
      pulse_start();
      lat = 0;
      while (!done && lat < 200) begin
        tick();
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
      chk($sformatf("v%0d_flags", i), {28'h0, pass, id_ok, ts_ok, timeout_err},
          {28'h0, vecs[i].e_flags});
      chk($sformatf("v%0d_id_value", i), id_value, vecs[i].e_idv);
      chk($sformatf("v%0d_ts_value", i), ts_value, vecs[i].e_tsv);
      tick();
      chk($sformatf("v%0d_idle_hold", i), {28'h0, busy, pass, timeout_err, done},
          {28'h0, 1'b0, vecs[i].e_flags[3], vecs[i].e_flags[0], 1'b0});
    end

    // Timeout waveform: two 4-cycle strobes, one gap cycle each, address held at 0.
    id_word = 32'h0; ts_word = TS; stall_id = 1000; stall_ts = 0;
    pulse_start();
    rdbits = '0; addr_any = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rdbits[c] = avm_read;
      addr_any  = addr_any | avm_address;
      tick();
    end
    chk("tmo_read_pattern", {22'h0, rdbits}, 32'h1EF);
    chk("tmo_addr_stable", {31'h0, addr_any}, 32'h0);
    chk("tmo_done", {29'h0, done, timeout_err, pass}, 32'h6);
    tick();
    chk("tmo_done_1cyc", {31'h0, done}, 32'h0);

    // Start while busy is dropped, not queued.
    stall_id = 0;
    pulse_start();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("busy_start_one_done", ndone, 1);
    chk("busy_start_pass", {31'h0, pass}, 32'h1);

    // Reset while stalled in the timestamp read, then auto-start resumes.
    stall_ts = 1000;
    pulse_start();
    tick();
    tick();
    chk("mid_rdts_active", {30'h0, avm_read, avm_address}, 32'h3);
    reset = 1'b1;
    tick();
    chk("mid_reset_ctrl", {28'h0, avm_read, avm_address, busy, done}, 32'h0);
    chk("mid_reset_stat", {28'h0, pass, id_ok, ts_ok, timeout_err}, 32'h0);
    chk("mid_reset_vals", id_value | ts_value, 32'h0);
    stall_ts = 0;
    reset = 1'b0;
    tick();
    chk("post_reset_auto", {30'h0, busy, avm_read}, 32'h3);
    tick(); tick(); tick();
    chk("post_reset_done", {29'h0, done, pass, timeout_err}, 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
